aes_key_expand_multi: RTL and testbench

Parametrised AES key-schedule engine that accepts a 128-, 192- or 256-bit cipher key, selected at run time, and streams all Nr+1 round keys. Keys can be emitted in forward order (encryption) or reverse order (decryption). Output uses a valid/ready handshake so the downstream round pipeline can stall it. It sits between the key-load register and the AES round datapath, replacing the fixed-length key-expansion blocks.

---
 rtl/aes_key_expand_multi.sv | 208 ++++++++++++++++++++
 tb/tb_aes_key_expand_multi.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_multi.sv
// AES key-schedule engine for 128/192/256-bit keys: streams the Nr+1 round keys
// in forward order, or (via a round-key buffer) in reverse order, over valid/ready.
module aes_key_expand_multi #(
  parameter int SUPPORT_REVERSE = 1,
  parameter int LANES           = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  input  logic         reverse,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         cfg_err
);

  if (LANES != 4) begin : g_lanes_check
    $error("aes_key_expand_multi: LANES must be 4");
  end

  typedef enum logic [1:0] {IDLE, GEN, FILL, DRAIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t       state;
  logic [31:0]  win [8];
  logic [31:0]  nwin [8];
  logic [2:0]   ph [4];
  logic [2:0]   ph_nx [4];
  logic [3:0]   nk, nr, cnt;
  logic [2:0]   base;
  logic [7:0]   rcon;
  logic         rcon_use, load, step;
  logic [255:0] kw;
  logic [127:0] cur_rk, next_rk, buf_rd;

  // Window holds w[i-8..i-1]; with i = Nk + 4r the round key r always sits at word 8-Nk.
  assign base    = 3'(4'd8 - nk);
  assign cur_rk  = {win[base], win[base + 3'd1], win[base + 3'd2], win[base + 3'd3]};
  assign next_rk = {nwin[base], nwin[base + 3'd1], nwin[base + 3'd2], nwin[base + 3'd3]};
  assign load    = (state == IDLE) && start && (key_len != 2'd3);
  assign step    = (state == FILL) || ((state == GEN) && rk_valid && rk_ready && !rk_last);

  always_comb begin
    case (key_len)
      2'd0:    kw = {128'h0, key_in[255:128]};
      2'd1:    kw = {64'h0, key_in[255:64]};
      default: kw = key_in;
    endcase
  end

  always_comb begin
    logic [31:0] prev, f;
    rcon_use = 1'b0;
    prev     = win[7];
    for (int l = 0; l < 4; l++) nwin[l] = win[l + 4];
    for (int l = 0; l < 4; l++) begin
      if (ph[l] == 3'd0) begin
        f        = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
        rcon_use = 1'b1;
      end else if ((nk == 4'd8) && (ph[l] == 3'd4)) begin
        f = sub_word(prev);
      end else begin
        f = prev;
      end
      prev        = win[base + 3'(l)] ^ f;
      nwin[l + 4] = prev;
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      ph_nx[l] = (({1'b0, ph[l]} + 4'd4) >= nk) ? 3'({1'b0, ph[l]} + 4'd4 - nk) : ph[l] + 3'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      case (key_len)
        2'd0:    begin nk <= 4'd4; nr <= 4'd10; end
        2'd1:    begin nk <= 4'd6; nr <= 4'd12; end
        default: begin nk <= 4'd8; nr <= 4'd14; end
      endcase
      for (int l = 0; l < 8; l++) win[l] <= kw[255 - 32*l -: 32];
      for (int l = 0; l < 4; l++) ph[l] <= 3'(l);
      rcon <= 8'h01;
    end else if (step) begin
      for (int l = 0; l < 8; l++) win[l] <= nwin[l];
      for (int l = 0; l < 4; l++) ph[l] <= ph_nx[l];
      if (rcon_use) rcon <= xtime(rcon);
    end
  end

  if (SUPPORT_REVERSE != 0) begin : g_buf
    logic [127:0] mem [15];
    always_ff @(posedge clk) begin
      if (state == FILL) mem[cnt] <= cur_rk;
    end
    assign buf_rd = mem[rk_index - 4'd1];
  end else begin : g_nobuf
    assign buf_rd = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      rk_last  <= 1'b0;
      cfg_err  <= 1'b0;
      cnt      <= '0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (key_len == 2'd3) begin
            cfg_err <= 1'b1;
          end else begin
            busy     <= 1'b1;
            rk_data  <= key_in[255:128];
            rk_index <= '0;
            rk_last  <= 1'b0;
            cnt      <= '0;
            if (reverse && (SUPPORT_REVERSE != 0)) begin
              state    <= FILL;
              rk_valid <= 1'b0;
            end else begin
              state    <= GEN;
              rk_valid <= 1'b1;
            end
          end
        end
        GEN: if (rk_valid && rk_ready) begin
          if (rk_last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
          end else begin
            rk_index <= rk_index + 4'd1;
            rk_data  <= next_rk;
            rk_last  <= (rk_index + 4'd1 == nr);
          end
        end
        FILL: begin
          cnt <= cnt + 4'd1;
          if (cnt == nr) begin
            state    <= DRAIN;
            rk_valid <= 1'b1;
            rk_data  <= cur_rk;
            rk_index <= nr;
          end
        end
        DRAIN: if (rk_valid && rk_ready) begin
          if (rk_last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
          end else begin
            rk_index <= rk_index - 4'd1;
            rk_data  <= buf_rd;
            rk_last  <= (rk_index == 4'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Directed bench for aes_key_expand_multi using FIPS-197 key-expansion vectors.
module tb_aes_key_expand_multi;

  localparam logic [127:0] K128    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] JUNK    = 128'h0123456789abcdef0fedcba987654321;
  localparam logic [127:0] RK1_128 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] RK0_192 = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] K256_HI = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] RK2_256 = 128'h9ba354118e6925afa51a8b5f2067fcde;

  logic         clk = 1'b0;
  logic         reset, start, reverse, rk_ready;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, rk_valid, rk_last, cfg_err;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;

  int checks = 0;
  int errors = 0;

  aes_key_expand_multi dut (
    .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key_in(key_in),
    .reverse(reverse), .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .rk_last(rk_last), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_fwd128(input string tag);
    key_len = 2'd0; key_in = {K128, JUNK}; reverse = 1'b0; rk_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    for (int n = 0; n <= 10; n++) begin
      check({tag, "_valid"}, rk_valid, 1);
      check({tag, "_idx"}, rk_index, n);
      check({tag, "_last"}, rk_last, (n == 10));
      if (n == 0)  check({tag, "_rk0"}, rk_data, K128);
      if (n == 1)  check({tag, "_rk1"}, rk_data, RK1_128);
      if (n == 10) check({tag, "_rk10"}, rk_data, RK10_128);
      tick();
    end
    check({tag, "_done_valid"}, rk_valid, 0);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  initial begin
    int hs, guard, c, n;
    logic stalled;
    logic [127:0] s_data;
    logic [3:0] s_idx;
    logic s_last;

    reset = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; reverse = 1'b0; rk_ready = 1'b0;
    repeat (3) tick();
    check("reset_ctrl", {busy, rk_valid, rk_last, cfg_err, rk_index}, 0);
    check("reset_data", rk_data, 0);
    reset = 1'b0;
    tick();

    run_fwd128("f128");

    // AES-192 with random backpressure
    key_len = 2'd1; key_in = {K192, 64'hdeadbeefcafef00d}; reverse = 1'b0; rk_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    hs = 0; guard = 0; stalled = 1'b0; s_data = '0; s_idx = '0; s_last = 1'b0;
    while (hs < 13 && guard < 200) begin
      if (stalled) begin
        check("s192_hold_data", rk_data, s_data);
        check("s192_hold_idx", rk_index, s_idx);
        check("s192_hold_last", rk_last, s_last);
      end
      rk_ready = (guard == 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
      if (rk_valid && rk_ready) begin
        check("s192_idx", rk_index, hs);
        check("s192_last", rk_last, (hs == 12));
        if (hs == 0)  check("s192_rk0", rk_data, RK0_192);
        if (hs == 12) check("s192_rk12", rk_data, RK12_192);
        hs++;
      end
      stalled = rk_valid && !rk_ready;
      s_data = rk_data; s_idx = rk_index; s_last = rk_last;
      tick();
      guard++;
    end
    check("s192_handshakes", hs, 13);
    check("s192_done_valid", rk_valid, 0);
    check("s192_done_busy", busy, 0);
    rk_ready = 1'b1;

    // AES-256 reverse
    key_len = 2'd2; key_in = K256; reverse = 1'b1; rk_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; reverse = 1'b0;
    check("r256_busy", busy, 1);
    c = 1;
    while (!rk_valid && c < 40) begin
      tick();
      c++;
    end
    check("r256_first_cycle", c, 16);
    for (int r = 14; r >= 0; r--) begin
      check("r256_idx", rk_index, r);
      check("r256_valid", rk_valid, 1);
      check("r256_last", rk_last, (r == 0));
      if (r == 14) check("r256_rk14", rk_data, RK14_256);
      if (r == 2)  check("r256_rk2", rk_data, RK2_256);
      if (r == 0)  check("r256_rk0", rk_data, K256_HI);
      tick();
    end
    check("r256_done_valid", rk_valid, 0);
    check("r256_done_busy", busy, 0);

    // Illegal key length
    key_len = 2'd3; key_in = K256; start = 1'b1;
    tick();
    start = 1'b0;
    check("ill_cfg_err", cfg_err, 1);
    check("ill_busy", busy, 0);
    check("ill_valid", rk_valid, 0);
    tick();
    check("ill_cfg_err_drop", cfg_err, 0);
    check("ill_busy2", busy, 0);
    check("ill_valid2", rk_valid, 0);

    // Reset in the middle of forward generation
    key_len = 2'd0; key_in = {K128, JUNK}; reverse = 1'b0; rk_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("mid_idx", rk_index, 4);
    reset = 1'b1;
    tick();
    check("mid_rst_ctrl", {busy, rk_valid, rk_last, cfg_err, rk_index}, 0);
    check("mid_rst_data", rk_data, 0);
    reset = 1'b0;
    run_fwd128("restart");

    // Back-to-back with start held high
    key_len = 2'd0; key_in = {K128, JUNK}; reverse = 1'b0; rk_ready = 1'b1; start = 1'b1;
    tick();
    for (int run = 0; run < 2; run++) begin
      n = 0;
      while (rk_valid && n < 20) begin
        check("b2b_idx", rk_index, n);
        n++;
        tick();
      end
      check("b2b_count", n, 11);
      check("b2b_gap_busy", busy, 0);
      tick();
      check("b2b_restart_valid", rk_valid, 1);
      check("b2b_restart_idx", rk_index, 0);
    end
    start = 1'b0;
    guard = 0;
    while (busy && guard < 30) begin
      tick();
      guard++;
    end
    check("b2b_final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
